// File: rtl/core_pkg.sv
// Shared widths and arbiter types for the core memory arbiter.
package core_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_W} arb_state_t;
  typedef enum logic {GRANT_INSTR = 1'b0, GRANT_DATA = 1'b1} arb_grant_t;
endpackage

// File: rtl/core_mem_arbiter_rr.sv
// Two-input round-robin picker; remembers which side won last.
module rr_arbiter2
  import core_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_instr,
  input  logic req_data,
  input  logic advance,
  output logic gnt_instr,
  output logic gnt_data
);
  arb_grant_t last_grant_q, last_grant_d;

  always_comb begin
    // Under contention the side that did not win last time goes first.
    gnt_instr    = req_instr & (~req_data | (last_grant_q == GRANT_DATA));
    gnt_data     = req_data & ~gnt_instr;
    last_grant_d = last_grant_q;
    if (advance && gnt_instr)     last_grant_d = GRANT_INSTR;
    else if (advance && gnt_data) last_grant_d = GRANT_DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= GRANT_DATA;
    else     last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one AXI-lite slave port between the fetch and LSU masters,
// one transaction at a time.
module core_mem_arbiter
  import core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] instr_ARADDR,
  input  logic                  instr_ARVALID,
  output logic                  instr_ARREADY,
  output logic [DATA_WIDTH-1:0] instr_RDATA,
  output logic                  instr_RVALID,
  input  logic                  instr_RREADY,
  input  logic [ADDR_WIDTH-1:0] data_ARADDR,
  input  logic                  data_ARVALID,
  output logic                  data_ARREADY,
  output logic [DATA_WIDTH-1:0] data_RDATA,
  output logic                  data_RVALID,
  input  logic                  data_RREADY,
  input  logic [ADDR_WIDTH-1:0] data_AWADDR,
  input  logic                  data_AWVALID,
  output logic                  data_AWREADY,
  input  logic [DATA_WIDTH-1:0] data_WDATA,
  input  logic                  data_WVALID,
  output logic                  data_WREADY,
  output logic [ADDR_WIDTH-1:0] mem_ARADDR,
  output logic                  mem_ARVALID,
  input  logic                  mem_ARREADY,
  input  logic [DATA_WIDTH-1:0] mem_RDATA,
  input  logic                  mem_RVALID,
  output logic                  mem_RREADY,
  output logic [ADDR_WIDTH-1:0] mem_AWADDR,
  output logic                  mem_AWVALID,
  input  logic                  mem_AWREADY,
  output logic [DATA_WIDTH-1:0] mem_WDATA,
  output logic                  mem_WVALID,
  input  logic                  mem_WREADY
);
  arb_state_t state_q, state_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       req_i, req_dr, req_dw;
  logic       gnt_instr, gnt_data;
  logic       in_idle;

  assign in_idle = (state_q == IDLE);
  assign req_i   = instr_ARVALID;
  assign req_dr  = data_ARVALID;
  assign req_dw  = data_AWVALID | data_WVALID;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_instr (req_i),
    .req_data  (req_dr | req_dw),
    .advance   (in_idle),
    .gnt_instr (gnt_instr),
    .gnt_data  (gnt_data)
  );

  always_comb begin
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    instr_ARREADY = 1'b0;
    instr_RDATA   = '0;
    instr_RVALID  = 1'b0;
    data_ARREADY  = 1'b0;
    data_RDATA    = '0;
    data_RVALID   = 1'b0;
    data_AWREADY  = 1'b0;
    data_WREADY   = 1'b0;
    mem_ARADDR    = '0;
    mem_ARVALID   = 1'b0;
    mem_RREADY    = 1'b0;
    mem_AWADDR    = '0;
    mem_AWVALID   = 1'b0;
    mem_WDATA     = '0;
    mem_WVALID    = 1'b0;
    case (state_q)
      IDLE: begin
        // Requests only steer the next state here; mem VALIDs wait a cycle.
        if (gnt_instr)     state_d = I_AR;
        else if (gnt_data) state_d = req_dw ? D_W : D_AR;
      end
      I_AR: begin
        mem_ARADDR    = instr_ARADDR;
        mem_ARVALID   = instr_ARVALID;
        instr_ARREADY = mem_ARREADY;
        if (instr_ARVALID && mem_ARREADY) state_d = I_R;
      end
      I_R: begin
        instr_RDATA  = mem_RDATA;
        instr_RVALID = mem_RVALID;
        mem_RREADY   = instr_RREADY;
        if (mem_RVALID && instr_RREADY) state_d = IDLE;
      end
      D_AR: begin
        mem_ARADDR   = data_ARADDR;
        mem_ARVALID  = data_ARVALID;
        data_ARREADY = mem_ARREADY;
        if (data_ARVALID && mem_ARREADY) state_d = D_R;
      end
      D_R: begin
        data_RDATA  = mem_RDATA;
        data_RVALID = mem_RVALID;
        mem_RREADY  = data_RREADY;
        if (mem_RVALID && data_RREADY) state_d = IDLE;
      end
      D_W: begin
        mem_AWADDR   = data_AWADDR;
        mem_AWVALID  = data_AWVALID & ~aw_done_q;
        data_AWREADY = mem_AWREADY & ~aw_done_q;
        mem_WDATA    = data_WDATA;
        mem_WVALID   = data_WVALID & ~w_done_q;
        data_WREADY  = mem_WREADY & ~w_done_q;
        aw_done_d    = aw_done_q | (data_AWVALID & mem_AWREADY);
        w_done_d     = w_done_q | (data_WVALID & mem_WREADY);
        if (aw_done_d && w_done_d) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameters: none; ADDR_WIDTH and DATA_WIDTH come from core_pkg.
REQ-002 clk  in  1  single clock for the whole block.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 instr_ARADDR/ARVALID in, instr_ARREADY out  ADDR_WIDTH/1/1  instruction read-address channel (fetch master).
REQ-005 instr_RDATA/RVALID out, instr_RREADY in  DATA_WIDTH/1/1  instruction read-data channel.
REQ-006 data_ARADDR/ARVALID in, data_ARREADY out  ADDR_WIDTH/1/1  LSU read-address channel.
REQ-007 data_RDATA/RVALID out, data_RREADY in  DATA_WIDTH/1/1  LSU read-data channel.
REQ-008 data_AWADDR/AWVALID in, data_AWREADY out  ADDR_WIDTH/1/1  LSU write-address channel.
REQ-009 data_WDATA/WVALID in, data_WREADY out  DATA_WIDTH/1/1  LSU write-data channel.
REQ-010 mem_AR*, mem_R*, mem_AW*, mem_W*  mirror directions  same widths  single shared AXI-lite slave port (no B channel).

Function
REQ-011 Clock and reset: one clock domain; reset is synchronous and active-high.
REQ-012 Exactly one transaction outstanding; FSM states IDLE, I_AR, I_R, D_AR, D_R, D_W.
REQ-013 Pending requests in IDLE: req_i = instr_ARVALID; req_dr = data_ARVALID; req_dw = data_AWVALID | data_WVALID.
REQ-014 Data-side selection: req_dw beats req_dr (write before read).
REQ-015 Instr vs data contention: 1-bit last_grant; grant the side not granted last; last_grant updates on entry to I_AR/D_AR/D_W.
REQ-016 A lone requester is granted regardless of last_grant.
REQ-017 Grant latency: request sampled in IDLE at cycle N; mem_*VALID first asserted at N+1; no combinational path from requester VALID to mem VALID while in IDLE.
REQ-018 In I_AR/D_AR: mem_AR* driven from owner; owner ARREADY = mem_ARREADY; on mem AR handshake go to I_R/D_R.
REQ-019 In I_R/D_R: owner RDATA/RVALID = mem_RDATA/RVALID; mem_RREADY = owner RREADY; on R handshake go to IDLE.
REQ-020 In D_W: AW and W forwarded independently; aw_done/w_done flags set on each handshake (both may occur in the same cycle); mem_AWVALID gated by !aw_done, mem_WVALID by !w_done; IDLE when both done, flags cleared.
REQ-021 Non-owner sees all READY=0 and RVALID=0; mem signals not owned by the current state are 0.
REQ-022 Requester dropping VALID before its handshake is a protocol violation; behaviour is undefined, and the FSM does not abandon the state.
REQ-023 Back-to-back: IDLE is entered for one cycle between transactions; minimum read occupancy is 3 cycles.

Reset
REQ-024 rst high: state=IDLE, last_grant=data (the instr side wins the first contention), aw_done=w_done=0.
REQ-025 All VALID/READY outputs are 0 in the cycle after rst is sampled high, including when rst hits mid-transaction; the in-flight transaction is discarded.

Structure
REQ-026 arb_state_t enum and arb_grant_t (GRANT_INSTR, GRANT_DATA) go in core_pkg.
REQ-027 Optional sub-module rr_arbiter2: 2-input round-robin with last_grant register; all else lives in core_mem_arbiter.
REQ-028 All output muxing is combinational from state; only state, last_grant, aw_done and w_done are registered.

Verification
REQ-029 instr AR 0x10 alone, mem ARREADY=1, RDATA=0xDEADBEEF one cycle later -> mem_ARVALID at N+1, instr_RVALID with 0xDEADBEEF, data side silent.
REQ-030 instr AR and data AR simultaneous after reset -> instr granted first; the next contention grants data; alternation holds for 4 rounds.
REQ-031 data AW 0x20 and W 0x55 simultaneously, mem AWREADY at +1 and WREADY at +3 -> AW presented once, W held until +3, IDLE after both.
REQ-032 data write and data read both pending (instr idle) -> write serviced first, read next.
REQ-033 rst asserted during I_R with mem_RVALID=0 -> next cycle all outputs 0 and state IDLE; a new request is accepted normally.
REQ-034 mem_RVALID with owner RREADY=0 for 3 cycles -> RDATA stable, no state change until RREADY=1.
